uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Receive half of the UART, directly downstream of the transmitter on the serial line.
- Oversamples the asynchronous rx pin against a shared oversample tick, validates the start bit, samples each data bit at mid-bit and checks the stop bit.
- Presents each received byte on a ready/read handshake to the CPU-side register interface, with framing-error and overrun flags.

Parameters:
- OVERSAMPLE, 16: tick pulses per bit period; power of two, minimum 4.
- DATA_BITS, 8: data bits per frame; LSB is received first.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- rx  in  1  serial line, asynchronous to Clock; idles at 1.
- tick  in  1  one-Clock-wide strobe at OVERSAMPLE x baud rate.
- rd_en  in  1  consumer acknowledges data_out; effective only while rdy=1.
- data_out  out  DATA_BITS  last good received word.
- rdy  out  1  data_out holds an unread word.
- frame_err  out  1  last completed frame had stop bit = 0.
- overrun  out  1  an unread word was overwritten.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, Reset_n=0):
  - Outputs: data_out=0, rdy=0, frame_err=0, overrun=0, rx_busy=0.
  - Internals: state=IDLE, synchronizer flops=1, counters=0.
  - Aborts any frame in progress.
- Synchronizer: rx passes through 2 flops, producing rx_s. All sampling uses rx_s only.
- Counters: sample counter of log2(OVERSAMPLE) bits; bit counter of log2(DATA_BITS) bits. Both advance only on Clock edges where tick=1.
- IDLE:
  - On tick with rx_s=0: go to START, sample counter=0.
  - Otherwise stay in IDLE.
- START:
  - Each tick increments the sample counter.
  - On the tick where the counter equals OVERSAMPLE/2-1 (mid start bit):
    - rx_s=0: go to DATA, sample counter=0, bit counter=0.
    - rx_s=1: false start; return to IDLE with no output change.
- DATA:
  - Each tick increments the sample counter.
  - At OVERSAMPLE-1: shift rx_s into the shift register MSB, shifting right (so the first bit lands in bit 0), and reset the sample counter to 0.
  - If bit counter = DATA_BITS-1, go to STOP; otherwise increment the bit counter.
- STOP: at sample counter OVERSAMPLE-1 (mid stop bit):
  - rx_s=1: data_out<=shift register, rdy<=1, frame_err<=0. overrun<=1 if rdy was already 1 and rd_en is not asserted this cycle.
  - rx_s=0: frame_err<=1; data_out, rdy and overrun unchanged.
  - Both cases: go to IDLE.
- Line held low (break): after a framing error, IDLE sees rx_s=0 and starts a new frame. Each subsequent frame also fails framing. No lockup.
- Handshake:
  - rd_en with rdy=1: rdy and overrun clear on the next edge.
  - rd_en with rdy=0: ignored.
  - frame_err is cleared only by the next good frame.
- Simultaneous good-frame completion and rd_en in the same cycle:
  - The new word loads and rdy stays 1.
  - overrun is neither set nor held; it clears.
- tick=0: all counters and state hold. tick held constantly high is legal (OVERSAMPLE Clocks per bit).
- Latency:
  - rdy rises on the Clock edge of the mid-stop-bit tick.
  - This is DATA_BITS+1.5 bit periods after start-edge detection, plus 2 Clocks of synchronizer delay, plus at most 1 tick of quantization.
- Width: all counters wrap naturally. No arithmetic beyond increment.

Test Plan:
1. Good frame: tick every cycle, OVERSAMPLE=16. Drive 16-cycle bits for 0xA5 (start 0, LSB first, stop 1). Required: data_out=0xA5, rdy=1, frame_err=0, overrun=0, rx_busy=0. Then pulse rd_en for 1 cycle; required: rdy=0 on the next edge.
2. Glitch rejection: rx low for 4 ticks, then high. Required: rx_busy pulses then returns to 0 before tick 8; rdy=0; data_out unchanged.
3. Framing error: send 0x3C with stop bit 0, then idle. Required: frame_err=1, rdy=0, data_out keeps its prior value. Then send a good 0x7E; required: frame_err=0, data_out=0x7E.
4. Overrun: send 0x11 then 0x22 back-to-back with no read. Required: data_out=0x22, rdy=1, overrun=1. One rd_en cycle clears both. Variant: assert rd_en exactly on the 0x22 completion edge; required: rdy=1, overrun=0.
5. Reset mid-frame: assert Reset_n=0 asynchronously after 4 data bits of 0xFF. Required: all outputs 0 immediately, without waiting for a clock edge. Release reset, send 0x5A; required: data_out=0x5A, rdy=1.
6. Loopback with uart_tx: drive the transmitter's per-bit tick at 1/16 of the rx tick rate and send 0x00, 0xFF and 0x81 in sequence, reading after each byte. Required: all three words received in order, no frame_err, no overrun.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Receive half of the UART. The asynchronous rx line is synchronized through
// two flops. A start bit is validated at its middle, each data bit is sampled
// at its middle (LSB first) and the stop bit is checked. Each good word is
// handed to the CPU side through a rdy / rd_en handshake.
//
// Parameters
//   OVERSAMPLE : tick pulses per bit period (power of two, >= 4)
//   DATA_BITS  : data bits per frame (>= 2), LSB received first
//
// Ports
//   Clock     in   system clock, all logic on the rising edge
//   Reset_n   in   asynchronous active-low reset, aborts any frame in progress
//   rx        in   serial line (asynchronous to Clock, idles high)
//   tick      in   one-Clock strobe at OVERSAMPLE x baud rate
//   rd_en     in   consumer acknowledge of data_out, effective while rdy = 1
//   data_out  out  last good received word
//   rdy       out  data_out holds an unread word
//   frame_err out  last completed frame had a low stop bit
//   overrun   out  an unread word was overwritten by a newer one
//   rx_busy   out  receiver is inside a frame (any state other than IDLE)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 rx,
    input  logic                 tick,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Sample-counter landmarks: middle of the start bit and end of a bit period.
    localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_r;
    logic [1:0]             sync_r;
    logic                   rx_s;
    logic [SCNT_W-1:0]      scnt_r;
    logic [BCNT_W-1:0]      bcnt_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic [DATA_BITS-1:0]   data_r;
    logic                   rdy_r;
    logic                   ferr_r;
    logic                   ovr_r;
    logic                   busy_r;

    // Two-flop synchronizer for the asynchronous serial line; resets to idle level.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx};
        end
    end

    assign rx_s = sync_r[1];

    // Frame receiver FSM with registered outputs and the CPU-side handshake.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
            scnt_r  <= '0;
            bcnt_r  <= '0;
            shift_r <= '0;
            data_r  <= '0;
            rdy_r   <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            // A read consumes the word. A good frame finishing on the same
            // edge overrides rdy below, and overrun then stays clear.
            if (rd_en && rdy_r) begin
                rdy_r <= 1'b0;
                ovr_r <= 1'b0;
            end

            if (tick) begin
                case (state_r)
                    IDLE: begin
                        if (!rx_s) begin
                            state_r <= START;
                            scnt_r  <= '0;
                            busy_r  <= 1'b1;
                        end
                    end

                    START: begin
                        if (scnt_r == SCNT_MID) begin
                            if (!rx_s) begin
                                state_r <= DATA;
                                scnt_r  <= '0;
                                bcnt_r  <= '0;
                            end else begin
                                // Line went back high before mid start bit: a glitch.
                                state_r <= IDLE;
                                scnt_r  <= '0;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            scnt_r <= scnt_r + SCNT_ONE;
                        end
                    end

                    DATA: begin
                        if (scnt_r == SCNT_LAST) begin
                            // Shift in from the top so the first (LSB) bit ends in bit 0.
                            shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
                            scnt_r  <= '0;
                            if (bcnt_r == BCNT_LAST) begin
                                state_r <= STOP;
                            end else begin
                                bcnt_r <= bcnt_r + BCNT_ONE;
                            end
                        end else begin
                            scnt_r <= scnt_r + SCNT_ONE;
                        end
                    end

                    STOP: begin
                        if (scnt_r == SCNT_LAST) begin
                            if (rx_s) begin
                                data_r <= shift_r;
                                rdy_r  <= 1'b1;
                                ferr_r <= 1'b0;
                                ovr_r  <= rdy_r && !rd_en;
                            end else begin
                                // Bad stop bit: keep the last good word untouched.
                                ferr_r <= 1'b1;
                            end
                            state_r <= IDLE;
                            scnt_r  <= '0;
                            busy_r  <= 1'b0;
                        end else begin
                            scnt_r <= scnt_r + SCNT_ONE;
                        end
                    end

                    default: begin
                        state_r <= IDLE;
                        scnt_r  <= '0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out  = data_r;
    assign rdy       = rdy_r;
    assign frame_err = ferr_r;
    assign overrun   = ovr_r;
    assign rx_busy   = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx. A behavioural receiver model counts ticks
// since start-edge detection and derives every sampling point arithmetically
// (mid start bit at OS/2, data bit i at OS/2 + OS*(i+1), stop at
// OS/2 + OS*(DB+1)). The DUT outputs are compared against it every cycle,
// and directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OS = 16;
    localparam int DB = 8;

    logic       Clock   = 1'b0;
    logic       Reset_n = 1'b1;
    logic       rx      = 1'b1;
    logic       tick    = 1'b0;
    logic       rd_en   = 1'b0;
    logic [7:0] data_out;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int n_checks  = 0;
    int n_fail    = 0;
    int tick_mode = 0;

    always #5 Clock = ~Clock;

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .rx        (rx),
        .tick      (tick),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    // ---------------------------------------------------------------- model
    typedef struct packed {
        logic        sy1;
        logic        sy2;
        logic        busy;
        logic [31:0] k;
        logic [7:0]  word;
        logic [7:0]  dout;
        logic        rdy;
        logic        ferr;
        logic        ovr;
    } mst_t;

    mst_t m;

    function automatic mst_t reset_state();
        mst_t r;
        r     = '0;
        r.sy1 = 1'b1;
        r.sy2 = 1'b1;
        return r;
    endfunction

    function automatic mst_t step(mst_t c, logic rxi, logic tk, logic rd);
        mst_t n;
        logic rxs;
        int   kk;
        int   idx;
        n     = c;
        rxs   = c.sy2;
        n.sy1 = rxi;
        n.sy2 = c.sy1;
        if (rd && c.rdy) begin
            n.rdy = 1'b0;
            n.ovr = 1'b0;
        end
        if (tk) begin
            if (!c.busy) begin
                if (!rxs) begin
                    n.busy = 1'b1;
                    n.k    = 32'd0;
                end
            end else begin
                kk  = int'(c.k) + 1;
                n.k = 32'(kk);
                if (kk == OS / 2) begin
                    if (rxs) n.busy = 1'b0;
                end else if (kk == OS / 2 + OS * (DB + 1)) begin
                    n.busy = 1'b0;
                    if (rxs) begin
                        n.dout = c.word;
                        n.rdy  = 1'b1;
                        n.ferr = 1'b0;
                        n.ovr  = c.rdy && !rd;
                    end else begin
                        n.ferr = 1'b1;
                    end
                end else if (kk > OS / 2 && ((kk - OS / 2) % OS) == 0) begin
                    idx         = (kk - OS / 2) / OS - 1;
                    n.word[idx] = rxs;
                end
            end
        end
        return n;
    endfunction

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) m <= reset_state();
        else          m <= step(m, rx, tick, rd_en);
    end

    // ---------------------------------------------------------------- checks
    task automatic check_cycle();
        logic [11:0] act;
        logic [11:0] exp;
        act = {data_out, rdy, frame_err, overrun, rx_busy};
        exp = {m.dout, m.rdy, m.ferr, m.ovr, m.busy};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, act, exp);
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    function automatic logic gen_tick();
        case (tick_mode)
            0:       return 1'b1;
            1:       return ($urandom_range(0, 3) != 0);
            default: return ($urandom_range(0, 7) == 0);
        endcase
    endfunction

    // One clock: compare on the falling edge, then drive just after the rising edge.
    task automatic cyc();
        @(negedge Clock);
        check_cycle();
        @(posedge Clock);
        #1;
        tick = gen_tick();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) cyc();
    endtask

    // Holds one bit for exactly OS ticks, acting as the transmitter's bit clock.
    task automatic send_bit(input logic b);
        int n;
        n  = 0;
        rx = b;
        while (n < OS) begin
            if (tick) n++;
            cyc();
        end
    endtask

    // rd_on_done (tick every cycle only) pulses rd_en on the mid-stop-bit edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd_on_done);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        if (rd_on_done) begin
            rx = 1'b1;
            repeat (10) cyc();
            rd_en = 1'b1;
            cyc();
            rd_en = 1'b0;
            repeat (5) cyc();
        end else begin
            send_bit(stop);
        end
    endtask

    task automatic read_word();
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        logic       saw_busy;
        logic [7:0] lb [3];
        logic [7:0] d;
        logic       stop;

        #2 Reset_n = 1'b0;
        repeat (3) cyc();
        check_lit("reset_state", 32'({data_out, rdy, frame_err, overrun, rx_busy}), 32'h0);
        Reset_n = 1'b1;
        tick_mode = 0;
        idle(20);

        // 1. good frame
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(4);
        check_lit("good_data", 32'(data_out), 32'hA5);
        check_lit("good_rdy", 32'(rdy), 32'h1);
        check_lit("good_ferr", 32'(frame_err), 32'h0);
        check_lit("good_ovr", 32'(overrun), 32'h0);
        check_lit("good_busy", 32'(rx_busy), 32'h0);
        read_word();
        check_lit("read_clears_rdy", 32'(rdy), 32'h0);

        // 2. glitch rejection
        rx = 1'b0;
        repeat (4) cyc();
        rx = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (rx_busy) saw_busy = 1'b1;
        end
        check_lit("glitch_busy_seen", 32'(saw_busy), 32'h1);
        check_lit("glitch_busy_end", 32'(rx_busy), 32'h0);
        check_lit("glitch_rdy", 32'(rdy), 32'h0);
        check_lit("glitch_data", 32'(data_out), 32'hA5);

        // 3. framing error then recovery
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(20);
        check_lit("ferr_set", 32'(frame_err), 32'h1);
        check_lit("ferr_rdy", 32'(rdy), 32'h0);
        check_lit("ferr_data_kept", 32'(data_out), 32'hA5);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(4);
        check_lit("ferr_cleared", 32'(frame_err), 32'h0);
        check_lit("recover_data", 32'(data_out), 32'h7E);
        read_word();

        // 4. overrun and simultaneous read
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(4);
        check_lit("ovr_data", 32'(data_out), 32'h22);
        check_lit("ovr_rdy", 32'(rdy), 32'h1);
        check_lit("ovr_set", 32'(overrun), 32'h1);
        read_word();
        check_lit("ovr_read_rdy", 32'(rdy), 32'h0);
        check_lit("ovr_read_ovr", 32'(overrun), 32'h0);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        idle(4);
        check_lit("simul_data", 32'(data_out), 32'h22);
        check_lit("simul_rdy", 32'(rdy), 32'h1);
        check_lit("simul_ovr", 32'(overrun), 32'h0);
        read_word();

        // Break: line held low keeps failing frames without lockup.
        rx = 1'b0;
        repeat (400) cyc();
        check_lit("break_ferr", 32'(frame_err), 32'h1);
        check_lit("break_rdy", 32'(rdy), 32'h0);
        idle(200);
        check_lit("break_idle", 32'(rx_busy), 32'h0);
        read_word();

        // 5. asynchronous reset mid-frame
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(4);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #2 Reset_n = 1'b0;
        #1 check_lit("async_reset", 32'({data_out, rdy, frame_err, overrun, rx_busy}), 32'h0);
        rx = 1'b1;
        repeat (3) cyc();
        Reset_n = 1'b1;
        idle(10);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(4);
        check_lit("post_reset_data", 32'(data_out), 32'h5A);
        check_lit("post_reset_rdy", 32'(rdy), 32'h1);
        read_word();

        // 6. loopback: transmitter bit clock is every 16th rx tick, irregular ticks
        tick_mode = 1;
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h81;
        for (int i = 0; i < 3; i++) begin
            send_frame(lb[i], 1'b1, 1'b0);
            idle(30);
            check_lit("loop_data", 32'(data_out), 32'(lb[i]));
            check_lit("loop_rdy", 32'(rdy), 32'h1);
            check_lit("loop_ferr", 32'(frame_err), 32'h0);
            check_lit("loop_ovr", 32'(overrun), 32'h0);
            read_word();
        end

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            tick_mode = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 4) == 0) rd_en = 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                rx = 1'b0;
                repeat ($urandom_range(1, 6)) cyc();
                idle(40);
            end
            send_frame(d, stop, 1'b0);
            rd_en = 1'b0;
            idle($urandom_range(0, 40));
            if ($urandom_range(0, 1) == 0) read_word();
        end
        tick_mode = 0;
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
